guess_round_controller: RTL and testbench

Sequencing controller for the number-guessing game. It steps the game through rounds 1–9 and drives `Max_digit`/`round` into the target-number lookup. It then waits out the lookup's registered latency, accepts player guesses over a valid/ready handshake, and compares each guess against the three target BCD digits. It tracks attempts and score, reports hints, and declares win or game over. It sits between the player-input/debounce logic and the display/LED feedback logic.

---
 rtl/guess_game_pkg.sv | 33 +++
 rtl/guess_round_controller_bcd3_compare.sv | 29 ++
 rtl/guess_round_controller.sv | 202 ++++++++++++++++++++
 tb/tb_guess_round_controller.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/guess_game_pkg.sv
// Shared types and constants for the number-guessing game controller.
package guess_game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GUESS = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [1:0] LEVEL_NONE = 2'b00;
    localparam logic [1:0] LEVEL_1DIG = 2'b01;
    localparam logic [1:0] LEVEL_2DIG = 2'b10;
    localparam logic [1:0] LEVEL_3DIG = 2'b11;

    localparam int ROUNDS_PER_LEVEL = 3;

    // Digit count for a round: three rounds per level, round 0 means no game.
    function automatic logic [1:0] round_to_level(input logic [3:0] r);
        if (r == 4'd0)
            return LEVEL_NONE;
        else if (int'(r) <= ROUNDS_PER_LEVEL)
            return LEVEL_1DIG;
        else if (int'(r) <= 2 * ROUNDS_PER_LEVEL)
            return LEVEL_2DIG;
        else
            return LEVEL_3DIG;
    endfunction

endpackage

// File: rtl/guess_round_controller_bcd3_compare.sv
// Combinational 3-digit BCD compare of a guess (a) against a target (b).
// With GUESS_HINT_EN undefined the magnitude compare is dropped and gt is 0.
module bcd3_compare
    import guess_game_pkg::*;
(
    input  bcd_digit_t a3,
    input  bcd_digit_t a2,
    input  bcd_digit_t a1,
    input  bcd_digit_t b3,
    input  bcd_digit_t b2,
    input  bcd_digit_t b1,
    output logic       eq,
    output logic       gt,
    output logic       invalid
);

    // Equality, guess validity and (optionally) lexicographic greater-than.
    always_comb begin
        eq      = ({a3, a2, a1} == {b3, b2, b1});
        invalid = (a3 > 4'd9) || (a2 > 4'd9) || (a1 > 4'd9);
`ifdef GUESS_HINT_EN
        gt = (a3 > b3) ||
             ((a3 == b3) && ((a2 > b2) || ((a2 == b2) && (a1 > b1))));
`else
        gt = 1'b0;
`endif
    end

endmodule

// File: rtl/guess_round_controller.sv
// Round sequencing controller for the number-guessing game.
// Optional feature: define GUESS_HINT_EN to enable too_high/too_low hints.
// Handshake: a guess transfers on a rising edge where guess_valid && guess_ready;
// guess_ready is high only in GUESS, so at most one guess every two cycles.
module guess_round_controller
    import guess_game_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 5,
    parameter int NUM_ROUNDS   = 9,
    parameter int LOAD_WAIT    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        guess_valid,
    input  logic [3:0]  guess_digit_3,
    input  logic [3:0]  guess_digit_2,
    input  logic [3:0]  guess_digit_1,
    input  logic [3:0]  target_digit_3,
    input  logic [3:0]  target_digit_2,
    input  logic [3:0]  target_digit_1,
    output logic [1:0]  Max_digit,
    output logic [3:0]  round,
    output logic        guess_ready,
    output logic        correct,
    output logic        too_high,
    output logic        too_low,
    output logic        bad_guess,
    output logic [3:0]  attempts_left,
    output logic [3:0]  score,
    output logic        busy,
    output logic        game_won,
    output logic        game_over,
    output game_state_t state_dbg
);

    localparam int         CW         = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;
    localparam logic [CW-1:0] LOAD_LAST = CW'(LOAD_WAIT - 1);
    localparam logic [3:0] ATT_INIT   = 4'(MAX_ATTEMPTS);
    localparam logic [3:0] ROUND_LAST = 4'(NUM_ROUNDS);

    game_state_t   state, state_n;
    logic [CW-1:0] load_cnt, load_cnt_n;
    bcd_digit_t    g3, g2, g1, g3_n, g2_n, g1_n;
    logic [3:0]    round_n, att_n, score_n;
    logic [1:0]    max_n;
    logic          correct_n, high_n, low_n, bad_n, won_n, over_n;

    bcd_digit_t    ca3, ca2, ca1, cb3, cb2, cb1;
    logic          cmp_eq, cmp_gt, cmp_invalid;

    // Digits above the current level compare as zero on both sides.
    always_comb begin
        ca3 = (Max_digit == LEVEL_3DIG) ? g3 : 4'd0;
        ca2 = Max_digit[1] ? g2 : 4'd0;
        ca1 = g1;
        cb3 = (Max_digit == LEVEL_3DIG) ? target_digit_3 : 4'd0;
        cb2 = Max_digit[1] ? target_digit_2 : 4'd0;
        cb1 = target_digit_1;
    end

    bcd3_compare u_cmp (
        .a3      (ca3),
        .a2      (ca2),
        .a1      (ca1),
        .b3      (cb3),
        .b2      (cb2),
        .b1      (cb1),
        .eq      (cmp_eq),
        .gt      (cmp_gt),
        .invalid (cmp_invalid)
    );

`ifndef GUESS_HINT_EN
    logic hint_unused;
    assign hint_unused = cmp_gt;
`endif

    // Next-state and next-register computation for the game sequence.
    always_comb begin
        state_n    = state;
        load_cnt_n = load_cnt;
        g3_n       = g3;
        g2_n       = g2;
        g1_n       = g1;
        round_n    = round;
        max_n      = Max_digit;
        att_n      = attempts_left;
        score_n    = score;
        correct_n  = 1'b0;
        high_n     = 1'b0;
        low_n      = 1'b0;
        bad_n      = 1'b0;
        won_n      = game_won;
        over_n     = game_over;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    round_n    = 4'd1;
                    max_n      = round_to_level(4'd1);
                    score_n    = 4'd0;
                    att_n      = ATT_INIT;
                    won_n      = 1'b0;
                    over_n     = 1'b0;
                    load_cnt_n = '0;
                    state_n    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_cnt == LOAD_LAST)
                    state_n = ST_GUESS;
                else
                    load_cnt_n = load_cnt + 1'b1;
            end
            ST_GUESS: begin
                if (guess_valid) begin
                    g3_n    = guess_digit_3;
                    g2_n    = guess_digit_2;
                    g1_n    = guess_digit_1;
                    state_n = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (cmp_invalid) begin
                    bad_n   = 1'b1;
                    state_n = ST_GUESS;
                end else if (cmp_eq) begin
                    correct_n = 1'b1;
                    score_n   = score + 4'd1;
                    if (round == ROUND_LAST) begin
                        won_n   = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        round_n    = round + 4'd1;
                        max_n      = round_to_level(round + 4'd1);
                        att_n      = ATT_INIT;
                        load_cnt_n = '0;
                        state_n    = ST_LOAD;
                    end
                end else begin
`ifdef GUESS_HINT_EN
                    high_n = cmp_gt;
                    low_n  = !cmp_gt;
`endif
                    att_n = attempts_left - 4'd1;
                    if (attempts_left == 4'd1) begin
                        over_n  = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_GUESS;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset dominates every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            load_cnt      <= '0;
            g3            <= 4'd0;
            g2            <= 4'd0;
            g1            <= 4'd0;
            round         <= 4'd0;
            Max_digit     <= LEVEL_NONE;
            attempts_left <= ATT_INIT;
            score         <= 4'd0;
            correct       <= 1'b0;
            too_high      <= 1'b0;
            too_low       <= 1'b0;
            bad_guess     <= 1'b0;
            game_won      <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state         <= state_n;
            load_cnt      <= load_cnt_n;
            g3            <= g3_n;
            g2            <= g2_n;
            g1            <= g1_n;
            round         <= round_n;
            Max_digit     <= max_n;
            attempts_left <= att_n;
            score         <= score_n;
            correct       <= correct_n;
            too_high      <= high_n;
            too_low       <= low_n;
            bad_guess     <= bad_n;
            game_won      <= won_n;
            game_over     <= over_n;
        end
    end

    // Status decoded directly from the state register.
    always_comb begin
        guess_ready = (state == ST_GUESS);
        busy        = (state == ST_LOAD) || (state == ST_GUESS) || (state == ST_CHECK);
        state_dbg   = state;
    end

endmodule

// File: tb/tb_guess_round_controller.sv
// Directed self-checking bench for guess_round_controller, including a
// registered model of the target lookup table.
module tb_guess_round_controller;
    import guess_game_pkg::*;

`ifdef GUESS_HINT_EN
    localparam bit HINT = 1'b1;
`else
    localparam bit HINT = 1'b0;
`endif

    logic        clk, reset, start, guess_valid;
    logic [3:0]  gd3, gd2, gd1;
    logic [3:0]  td3, td2, td1;
    logic [1:0]  max_digit;
    logic [3:0]  round, attempts_left, score;
    logic        guess_ready, correct, too_high, too_low, bad_guess;
    logic        busy, game_won, game_over;
    game_state_t state_dbg;

    int checks = 0;
    int errors = 0;

    guess_round_controller dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .guess_valid    (guess_valid),
        .guess_digit_3  (gd3),
        .guess_digit_2  (gd2),
        .guess_digit_1  (gd1),
        .target_digit_3 (td3),
        .target_digit_2 (td2),
        .target_digit_1 (td1),
        .Max_digit      (max_digit),
        .round          (round),
        .guess_ready    (guess_ready),
        .correct        (correct),
        .too_high       (too_high),
        .too_low        (too_low),
        .bad_guess      (bad_guess),
        .attempts_left  (attempts_left),
        .score          (score),
        .busy           (busy),
        .game_won       (game_won),
        .game_over      (game_over),
        .state_dbg      (state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Target lookup model: registered, updates only on a consistent level/round pair.
    function automatic logic [1:0] tb_level(input logic [3:0] r);
        case (r)
            4'd1, 4'd2, 4'd3: return 2'b01;
            4'd4, 4'd5, 4'd6: return 2'b10;
            4'd7, 4'd8, 4'd9: return 2'b11;
            default:          return 2'b00;
        endcase
    endfunction

    function automatic logic [11:0] tb_table(input logic [3:0] r);
        case (r)
            4'd1: return 12'h002;
            4'd2: return 12'h008;
            4'd3: return 12'h003;
            4'd4: return 12'h057;
            4'd5: return 12'h096;
            4'd6: return 12'h021;
            4'd7: return 12'h123;
            4'd8: return 12'h555;
            4'd9: return 12'h999;
            default: return 12'h000;
        endcase
    endfunction

    always @(posedge clk) begin
        if (max_digit == tb_level(round))
            {td3, td2, td1} <= tb_table(round);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Result pulses packed as {correct, too_high, too_low, bad_guess, attempts_left}.
    task automatic chk_result(input string tag, input logic c, input logic h, input logic l,
                              input logic b, input logic [3:0] att);
        chk(tag, {correct, too_high, too_low, bad_guess, attempts_left},
            {c, h & HINT, l & HINT, b, att});
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!guess_ready && n < 20) begin
            tick();
            n++;
        end
        chk(tag, 16'(guess_ready), 16'd1);
    endtask

    // Present one guess, let it be accepted, and stop just after the result edge.
    task automatic do_guess(input logic [11:0] v);
        wait_ready("ready_wait");
        guess_valid = 1'b1;
        {gd3, gd2, gd1} = v;
        tick();
        guess_valid = 1'b0;
        chk("ready_drop", 16'(guess_ready), 16'd0);
        tick();
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_rnd"}, {10'd0, max_digit, round}, 16'h0000);
        chk({tag, "_out"}, {guess_ready, correct, too_high, too_low, bad_guess,
                            busy, game_won, game_over, attempts_left, score}, 16'h0050);
        chk({tag, "_st"}, 16'(state_dbg), 16'(ST_IDLE));
    endtask

    logic [11:0] tgt [9];
    logic [1:0]  nxt_lvl [9];

    initial begin
        tgt     = '{12'h002, 12'h008, 12'h003, 12'h057, 12'h096,
                    12'h021, 12'h123, 12'h555, 12'h999};
        nxt_lvl = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
        reset = 1'b1;
        start = 1'b1;
        guess_valid = 1'b0;
        {gd3, gd2, gd1} = 12'h000;
        tick();
        tick();
        chk_reset_values("reset_with_start");
        start = 1'b0;
        reset = 1'b0;
        tick();

        // Start and round load latency.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_round", {10'd0, max_digit, round}, 16'h0011);
        chk("start_busy", {busy, guess_ready, attempts_left}, {2'b10, 4'd5});
        tick();
        chk("load_ready_lo", 16'(guess_ready), 16'd0);
        tick();
        chk("load_ready_hi", 16'(guess_ready), 16'd1);

        // Rounds 1-4 solved directly.
        for (int r = 1; r <= 4; r++) begin
            do_guess(tgt[r-1]);
            chk_result($sformatf("win_r%0d_res", r), 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
            chk($sformatf("win_r%0d_rnd", r), {6'd0, nxt_lvl[r-1], 4'(r), 4'(r + 1)},
                {6'd0, max_digit, score, round});
        end

        // Round 5 (target 96): hints, then a bad guess, then the answer.
        do_guess(12'h097);
        chk_result("hint_high", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        chk("retry_ready", {14'd0, guess_ready, busy}, 16'h0003);
        do_guess(12'h050);
        chk_result("hint_low", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        do_guess(12'h09A);
        chk_result("bad_guess", 1'b0, 1'b0, 1'b0, 1'b1, 4'd3);
        chk("bad_state", 16'(state_dbg), 16'(ST_GUESS));
        do_guess(12'h096);
        chk_result("win_r5_res", 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        chk("win_r5_rnd", {6'd0, max_digit, score, round}, {6'd0, 2'b10, 4'd5, 4'd6});

        // Rounds 6-9 through to the win.
        for (int r = 6; r <= 9; r++) begin
            do_guess(tgt[r-1]);
            chk_result($sformatf("win_r%0d_res", r), 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
            chk($sformatf("win_r%0d_rnd", r),
                {6'd0, nxt_lvl[r-1], 4'(r), (r == 9) ? 4'd9 : 4'(r + 1)},
                {6'd0, max_digit, score, round});
        end
        chk("won_flags", {11'd0, game_won, game_over, busy, guess_ready, 1'b0}, 16'h0010);
        chk("won_state", 16'(state_dbg), 16'(ST_DONE));
        tick();
        chk("pulse_width", 16'(correct), 16'd0);
        chk("won_hold", {11'd0, game_won, score}, {11'd0, 1'b1, 4'd9});

        // Restart from DONE, then lose round 1 (target 2).
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_won", {7'd0, game_won, score, round}, {7'd0, 1'b0, 4'd0, 4'd1});
        do_guess(12'h005);
        chk_result("lose_1", 1'b0, 1'b1, 1'b0, 1'b0, 4'd4);
        do_guess(12'h001);
        chk_result("lose_2", 1'b0, 1'b0, 1'b1, 1'b0, 4'd3);
        do_guess(12'h009);
        chk_result("lose_3", 1'b0, 1'b1, 1'b0, 1'b0, 4'd2);
        do_guess(12'h000);
        chk_result("lose_4", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1);
        do_guess(12'h007);
        chk_result("lose_5", 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("over_flags", {12'd0, game_over, game_won, guess_ready, busy}, 16'h0008);
        chk("over_state", 16'(state_dbg), 16'(ST_DONE));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_over", {7'd0, game_over, attempts_left, round}, {7'd0, 1'b0, 4'd5, 4'd1});

        // Solve round 1, check start is ignored in LOAD, then reset mid-guess.
        do_guess(12'h002);
        chk_result("pre_reset_win", 1'b1, 1'b0, 1'b0, 1'b0, 4'd5);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored", {8'd0, score, round}, {8'd0, 4'd1, 4'd2});
        wait_ready("reset_wait");
        reset = 1'b1;
        guess_valid = 1'b1;
        {gd3, gd2, gd1} = 12'h008;
        tick();
        chk_reset_values("reset_mid");
        tick();
        chk("reset_no_pulse", {12'd0, correct, too_high, too_low, bad_guess}, 16'h0000);
        reset = 1'b0;
        guess_valid = 1'b0;
        tick();
        chk_reset_values("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
